// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester operand arbiter: default width,
// source encodings and the output-register FSM state type.
package arb_pkg;

  localparam int   DATA_W_DEF = 64;
  localparam logic SRC_A      = 1'b1;
  localparam logic SRC_B      = 1'b0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux2x1.sv
// DATA_W-wide 2:1 payload multiplexer; sel=1 selects input a.
module mux2x1 #(
  parameter int W = 64
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/operand_arbiter.sv
// Two-requester arbiter feeding a single registered output slot.
// Define ARB_FIXED_PRIO_EN for fixed priority (A wins); default is round-robin.
//
// state | meaning
// EMPTY | output register holds nothing, out_valid=0
// FULL  | output register holds a payload, out_valid=1
module operand_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
);

  arb_state_t        state;
  logic              load_en;
  logic              grant_any;
  logic [DATA_W-1:0] mux_data;

  assign load_en = (state == EMPTY) || out_ready;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset && load_en) begin
      a_ready = a_valid;
      b_ready = b_valid && !a_valid;
    end
  end
`else
  logic last_grant;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset && load_en) begin
      if (a_valid && b_valid) begin
        a_ready = (last_grant == SRC_B);
        b_ready = (last_grant == SRC_A);
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= SRC_B;
    else if (a_ready || b_ready)
      last_grant <= a_ready ? SRC_A : SRC_B;
  end
`endif

  assign grant_any = a_ready || b_ready;

  mux2x1 #(.W(DATA_W)) u_payload_mux (
    .sel (a_ready),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_B;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_any) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= a_ready ? SRC_A : SRC_B;
          end
        end
        FULL: begin
          if (grant_any) begin
            out_data <= mux_data;
            out_src  <= a_ready ? SRC_A : SRC_B;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_arbiter.sv
// Directed table-driven bench for operand_arbiter plus hand sequences for
// reset corners; expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_operand_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_src;
  logic        out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  operand_arbiter #(.DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [63:0] ad;
    logic        bv;
    logic [63:0] bd;
    logic        ordy;
    logic        ear;
    logic        ebr;
    logic        eov;
    logic [63:0] eod;
    logic        esrc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic av, logic [63:0] ad, logic bv, logic [63:0] bd,
                              logic ordy, logic ear, logic ebr, logic eov,
                              logic [63:0] eod, logic esrc);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr; v.eov = eov; v.eod = eod; v.esrc = esrc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Starting after reset: EMPTY, last grant = B.
    vt.push_back(mk(1, 64'h1111, 0, 64'h0,    1, 1, 0, 1, 64'h1111, 1));
    vt.push_back(mk(0, 64'h0,    1, 64'h2222, 1, 0, 1, 1, 64'h2222, 0));
    // Contention with out_ready=1: RR gives A,B,A,B; fixed gives A every cycle.
    vt.push_back(mk(1, 64'hA0, 1, 64'hB0, 1, 1, 0, 1, 64'hA0, 1));
    vt.push_back(mk(1, 64'hA1, 1, 64'hB1, 1, FIX, !FIX, 1, FIX ? 64'hA1 : 64'hB1, FIX));
    vt.push_back(mk(1, 64'hA2, 1, 64'hB2, 1, 1, 0, 1, 64'hA2, 1));
    vt.push_back(mk(1, 64'hA3, 1, 64'hB3, 1, FIX, !FIX, 1, FIX ? 64'hA3 : 64'hB3, FIX));
    vt.push_back(mk(1, 64'hDEAD, 0, 64'h0, 1, 1, 0, 1, 64'hDEAD, 1));
    // Stall for 5 cycles: nothing granted, DEAD held.
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 64'h3333, 1, 64'h4444, 0, 0, 0, 1, 64'hDEAD, 1));
    vt.push_back(mk(0, 64'h0, 1, 64'h2222, 1, 0, 1, 1, 64'h2222, 0));
    vt.push_back(mk(0, 64'h0, 0, 64'h0,    0, 0, 0, 1, 64'h2222, 0));
    vt.push_back(mk(0, 64'h0, 0, 64'h0,    1, 0, 0, 0, 64'h2222, 0));
    vt.push_back(mk(0, 64'h0, 0, 64'h0,    0, 0, 0, 0, 64'h2222, 0));
    // EMPTY accepts even without out_ready.
    vt.push_back(mk(1, 64'h5555, 0, 64'h0, 0, 1, 0, 1, 64'h5555, 1));
    vt.push_back(mk(1, 64'h6666, 1, 64'h7777, 0, 0, 0, 1, 64'h5555, 1));

    reset = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 64'hFFFF; b_data = 64'hEEEE;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_out_src",   {63'b0, out_src}, 64'd0);
    chk("rst_a_ready",   {63'b0, a_ready}, 64'd0);
    chk("rst_b_ready",   {63'b0, b_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vt[i]) begin
      a_valid = vt[i].av; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_data = vt[i].bd;
      out_ready = vt[i].ordy;
      #3;
      chk($sformatf("v%0d_a_ready", i), {63'b0, a_ready}, {63'b0, vt[i].ear});
      chk($sformatf("v%0d_b_ready", i), {63'b0, b_ready}, {63'b0, vt[i].ebr});
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {63'b0, out_valid}, {63'b0, vt[i].eov});
      chk($sformatf("v%0d_out_data", i),  out_data, vt[i].eod);
      chk($sformatf("v%0d_out_src", i),   {63'b0, out_src}, {63'b0, vt[i].esrc});
    end

    // Asynchronous reset while the output register is full.
    chk("pre_async_valid", {63'b0, out_valid}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_out_data",  out_data, 64'd0);
    chk("async_a_ready",   {63'b0, a_ready}, 64'd0);
    chk("async_b_ready",   {63'b0, b_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First contention after reset grants A.
    a_valid = 1'b1; a_data = 64'h8888;
    b_valid = 1'b1; b_data = 64'h9999;
    out_ready = 1'b1;
    #3;
    chk("post_rst_a_ready", {63'b0, a_ready}, 64'd1);
    chk("post_rst_b_ready", {63'b0, b_ready}, 64'd0);
    @(posedge clk); #1;
    chk("post_rst_out_src",  {63'b0, out_src}, 64'd1);
    chk("post_rst_out_data", out_data, 64'h8888);
    #3;
    chk("post_rst2_a_ready", {63'b0, a_ready}, {63'b0, FIX});
    chk("post_rst2_b_ready", {63'b0, b_ready}, {63'b0, !FIX});
    @(posedge clk); #1;
    chk("post_rst2_out_data", out_data, FIX ? 64'h8888 : 64'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
